// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one burst memory port between icache refills
// and dcache refill/writeback bursts, one whole BEATS-beat burst per grant.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   ic_req/ic_addr    icache burst request; ic_gnt pulses on acceptance
//   ic_rdata/rvalid/rlast  read beats routed to the icache
//   dc_req/dc_addr/dc_we   dcache burst request (we=1 writeback)
//   dc_wdata/dc_wnext      writeback beat and its consume strobe
//   dc_gnt, dc_rdata/rvalid/rlast  dcache grant and read beats
//   mem_req/addr/we/ack    burst request handshake to memory
//   mem_wdata/wready       write beat to memory
//   mem_rdata/rvalid       read beat from memory
//
// Build option: MEM_ARB_DC_PRIORITY_EN makes the dcache win every tie
// (fixed priority); otherwise ties alternate round-robin.

module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_rvalid,
    output logic              ic_rlast,

    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic              dc_we,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wnext,
    output logic              dc_gnt,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_rvalid,
    output logic              dc_rlast,

    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_wready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    // Owner encoding: 0 = icache, 1 = dcache.
    logic              r_owner;
    logic              w_owner_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_tie_owner;
    logic              w_pick;
    logic              w_beat;
    logic              w_last_beat;

`ifdef MEM_ARB_DC_PRIORITY_EN
    assign w_tie_owner = 1'b1;
`else
    logic r_last_owner;
    logic w_last_nxt;
    // The side that did not own the previous burst wins a tie.
    assign w_tie_owner = ~r_last_owner;
`endif

    assign w_pick      = (ic_req && dc_req) ? w_tie_owner : dc_req;
    assign w_last_beat = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
`ifndef MEM_ARB_DC_PRIORITY_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_addr  <= w_addr_nxt;
            r_we    <= w_we_nxt;
            r_cnt   <= w_cnt_nxt;
`ifndef MEM_ARB_DC_PRIORITY_EN
            r_last_owner <= w_last_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_addr_nxt  = r_addr;
        w_we_nxt    = r_we;
        w_cnt_nxt   = r_cnt;
`ifndef MEM_ARB_DC_PRIORITY_EN
        w_last_nxt  = r_last_owner;
`endif
        w_beat      = 1'b0;
        ic_gnt      = 1'b0;
        ic_rdata    = '0;
        ic_rvalid   = 1'b0;
        ic_rlast    = 1'b0;
        dc_gnt      = 1'b0;
        dc_rdata    = '0;
        dc_rvalid   = 1'b0;
        dc_rlast    = 1'b0;
        dc_wnext    = 1'b0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;

        unique case (r_state)
            S_IDLE: begin
                if (ic_req || dc_req) begin
                    w_owner_nxt = w_pick;
                    w_addr_nxt  = w_pick ? dc_addr : ic_addr;
                    w_we_nxt    = w_pick & dc_we;
                    w_state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                mem_req  = 1'b1;
                mem_addr = r_addr;
                mem_we   = r_we;
                if (mem_ack) begin
                    ic_gnt      = ~r_owner;
                    dc_gnt      = r_owner;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                mem_we = r_we;
                if (r_we) begin
                    // Writebacks always belong to the dcache.
                    mem_wdata = dc_wdata;
                    dc_wnext  = mem_wready;
                    w_beat    = mem_wready;
                    dc_rlast  = mem_wready & w_last_beat;
                end else begin
                    w_beat    = mem_rvalid;
                    ic_rvalid = mem_rvalid & ~r_owner;
                    dc_rvalid = mem_rvalid & r_owner;
                    ic_rlast  = ic_rvalid & w_last_beat;
                    dc_rlast  = dc_rvalid & w_last_beat;
                    ic_rdata  = r_owner ? '0 : mem_rdata;
                    dc_rdata  = r_owner ? mem_rdata : '0;
                end
                if (w_beat) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    if (w_last_beat) begin
                        w_state_nxt = S_IDLE;
`ifndef MEM_ARB_DC_PRIORITY_EN
                        w_last_nxt  = r_owner;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter: random and directed bursts against a
// transaction-level model of the arbiter's grant order and beat routing.

module tb_mem_port_arbiter;

    localparam int NB = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ic_req;
    logic [63:0] ic_addr;
    logic        ic_gnt;
    logic [63:0] ic_rdata;
    logic        ic_rvalid;
    logic        ic_rlast;
    logic        dc_req;
    logic [63:0] dc_addr;
    logic        dc_we;
    logic [63:0] dc_wdata;
    logic        dc_wnext;
    logic        dc_gnt;
    logic [63:0] dc_rdata;
    logic        dc_rvalid;
    logic        dc_rlast;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_we;
    logic        mem_ack;
    logic [63:0] mem_wdata;
    logic        mem_wready;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;

    int          n_chk = 0;
    int          n_err = 0;
    bit          last_own;
    logic [63:0] wexp [NB];
    logic [63:0] wq [$];

    mem_port_arbiter #(
        .ADDR_W(64),
        .DATA_W(64),
        .BEATS (NB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_gnt    (ic_gnt),
        .ic_rdata  (ic_rdata),
        .ic_rvalid (ic_rvalid),
        .ic_rlast  (ic_rlast),
        .dc_req    (dc_req),
        .dc_addr   (dc_addr),
        .dc_we     (dc_we),
        .dc_wdata  (dc_wdata),
        .dc_wnext  (dc_wnext),
        .dc_gnt    (dc_gnt),
        .dc_rdata  (dc_rdata),
        .dc_rvalid (dc_rvalid),
        .dc_rlast  (dc_rlast),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_ack   (mem_ack),
        .mem_wdata (mem_wdata),
        .mem_wready(mem_wready),
        .mem_rdata (mem_rdata),
        .mem_rvalid(mem_rvalid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_ic_gnt"}, ic_gnt, 0);
        chk({tag, "_dc_gnt"}, dc_gnt, 0);
        chk({tag, "_ic_rvalid"}, ic_rvalid, 0);
        chk({tag, "_dc_rvalid"}, dc_rvalid, 0);
        chk({tag, "_ic_rlast"}, ic_rlast, 0);
        chk({tag, "_dc_rlast"}, dc_rlast, 0);
        chk({tag, "_wnext"}, dc_wnext, 0);
        chk({tag, "_mem_req"}, mem_req, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Expected winner: sole requester, else tie rule. 1 = dcache.
    function automatic bit pick();
        if (ic_req && !dc_req) return 1'b0;
        if (dc_req && !ic_req) return 1'b1;
`ifdef MEM_ARB_DC_PRIORITY_EN
        return 1'b1;
`else
        return !last_own;
`endif
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        ic_req     = 1'b0;
        dc_req     = 1'b0;
        mem_ack    = 1'b0;
        mem_rvalid = 1'b0;
        mem_wready = 1'b0;
        step();
        reset    = 1'b0;
        last_own = 1'b1;
        #1 quiet("post_rst");
        step();
    endtask

    // Caller has raised requests at a negedge with the arbiter idle.
    task automatic do_burst(input int ack_dly, input bit stall,
                            input int abort_at);
        bit          own;
        bit          fire;
        logic        we;
        logic [63:0] a;
        logic [63:0] d;
        int          beat;
        int          cyc;
        int          nw;
        own = pick();
        a   = own ? dc_addr : ic_addr;
        we  = own & dc_we;
        #1 quiet("idle");
        step();
        for (int k = 0; k <= ack_dly; k++) begin
            mem_ack = (k == ack_dly);
            #1;
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, a);
            chk("mem_we", mem_we, we);
            chk("ic_gnt", ic_gnt, (k == ack_dly) && !own);
            chk("dc_gnt", dc_gnt, (k == ack_dly) && own);
            step();
        end
        mem_ack = 1'b0;
        if (own) dc_req = 1'b0;
        else ic_req = 1'b0;
        beat = 0;
        cyc  = 0;
        nw   = 0;
        wq.delete();
        while (beat < NB && cyc < 100) begin
            if (beat == abort_at) begin
                do_reset();
                return;
            end
            fire = stall ? cyc[0] : ($urandom_range(0, 3) != 0);
            if (!we) begin
                d          = {$urandom, $urandom};
                mem_rdata  = d;
                mem_rvalid = fire;
                #1;
                chk("ic_rvalid", ic_rvalid, fire && !own);
                chk("dc_rvalid", dc_rvalid, fire && own);
                chk("ic_rlast", ic_rlast, fire && !own && beat == NB - 1);
                chk("dc_rlast", dc_rlast, fire && own && beat == NB - 1);
                chk("rd_wnext", dc_wnext, 0);
                if (fire) chk("rdata", own ? dc_rdata : ic_rdata, d);
            end else begin
                dc_wdata   = wexp[beat];
                mem_wready = fire;
                #1;
                chk("mem_wdata", mem_wdata, wexp[beat]);
                chk("wnext", dc_wnext, fire);
                chk("wr_rlast", dc_rlast, fire && beat == NB - 1);
                chk("wr_ic_rvalid", ic_rvalid, 0);
                chk("wr_dc_rvalid", dc_rvalid, 0);
                if (fire) begin
                    wq.push_back(mem_wdata);
                    nw++;
                end
            end
            step();
            if (fire) beat++;
            cyc++;
        end
        mem_rvalid = 1'b0;
        mem_wready = 1'b0;
        chk("burst_beats", beat, NB);
        last_own = own;
        if (we) begin
            chk("wnext_cnt", nw, NB);
            for (int i = 0; i < wq.size(); i++)
                chk("wseq", wq[i], wexp[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        ic_req     = 1'b0;
        ic_addr    = '0;
        dc_req     = 1'b0;
        dc_addr    = '0;
        dc_we      = 1'b0;
        dc_wdata   = '0;
        mem_ack    = 1'b0;
        mem_wready = 1'b0;
        mem_rdata  = '0;
        mem_rvalid = 1'b0;
        last_own   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 quiet("rst");
        @(negedge clk);
        reset = 1'b0;
        #1 quiet("reset");
        step();

        ic_req  = 1'b1;
        ic_addr = 64'h1000;
        do_burst(2, 1'b0, -1);

        for (int i = 0; i < 3; i++) begin
            mem_rvalid = 1'b1;
            mem_wready = 1'b1;
            mem_rdata  = {$urandom, $urandom};
            #1;
            chk("stray_ic_rvalid", ic_rvalid, 0);
            chk("stray_dc_rvalid", dc_rvalid, 0);
            chk("stray_wnext", dc_wnext, 0);
            step();
        end
        mem_rvalid = 1'b0;
        mem_wready = 1'b0;

        do_reset();
        for (int r = 0; r < 2; r++) begin
            ic_req  = 1'b1;
            ic_addr = 64'h2000 + 64'(r) * 64'h40;
            dc_req  = 1'b1;
            dc_addr = 64'h8000 + 64'(r) * 64'h40;
            dc_we   = 1'b0;
            do_burst(1, 1'b0, -1);
            do_burst(0, 1'b0, -1);
        end

        dc_req  = 1'b1;
        dc_addr = 64'h4000;
        dc_we   = 1'b1;
        for (int i = 0; i < NB; i++) wexp[i] = 64'hA0 + 64'(i);
        do_burst(1, 1'b1, -1);

        ic_req  = 1'b1;
        ic_addr = 64'h3040;
        do_burst(20, 1'b0, -1);

        ic_req  = 1'b1;
        ic_addr = 64'h5000;
        do_burst(1, 1'b0, 3);
        dc_req  = 1'b1;
        dc_addr = 64'h6000;
        dc_we   = 1'b0;
        do_burst(0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            if (!ic_req && $urandom_range(0, 1) == 1) begin
                ic_req  = 1'b1;
                ic_addr = {$urandom, $urandom} & ~64'h3F;
            end
            if (!dc_req && $urandom_range(0, 1) == 1) begin
                dc_req  = 1'b1;
                dc_addr = {$urandom, $urandom} & ~64'h3F;
                dc_we   = 1'($urandom_range(0, 1));
                for (int i = 0; i < NB; i++) wexp[i] = {$urandom, $urandom};
            end
            if (!ic_req && !dc_req) begin
                ic_req  = 1'b1;
                ic_addr = {$urandom, $urandom} & ~64'h3F;
            end
            do_burst($urandom_range(0, 3), 1'b0, -1);
        end
        while (ic_req || dc_req) do_burst(1, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
